// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback request type and default widths
package wb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF = 5;
  typedef struct packed {
    logic [AW_DEF-1:0] rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: ALU/LSU writeback inputs and regfile write-port outputs
import wb_pkg::*;
interface regfile_wb_ctrl_if #(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = AW_DEF,
  parameter int DEPTH = 2
);
  logic i_alu_valid;
  logic [AW-1:0] i_alu_rd;
  logic [XLEN-1:0] i_alu_data;
  logic i_lsu_valid;
  logic o_lsu_ready;
  logic [AW-1:0] i_lsu_rd;
  logic [XLEN-1:0] i_lsu_data;
  logic o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [XLEN-1:0] o_wr_data;
  logic [$clog2(DEPTH+1)-1:0] o_fifo_count;
  modport slave (
    input i_alu_valid, i_alu_rd, i_alu_data, i_lsu_valid, i_lsu_rd, i_lsu_data,
    output o_lsu_ready, o_wr_en, o_wr_addr, o_wr_data, o_fifo_count
  );
  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data, i_lsu_valid, i_lsu_rd, i_lsu_data,
    input o_lsu_ready, o_wr_en, o_wr_addr, o_wr_data, o_fifo_count
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: circular FIFO of writeback requests, any DEPTH >= 1
import wb_pkg::*;
module wb_fifo #(
  parameter type T = wb_req_t,
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T data_i,
  input  logic pop_i,
  output T data_o,
  output logic full_o,
  output logic empty_o,
  output logic [CW-1:0] count_o
);
  if (DEPTH < 1) begin : g_bad_depth
    $error("wb_fifo: DEPTH must be at least 1");
  end
  T mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= inc(wp_q);
      if (pop_i) rp_q <= inc(rp_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= data_i;
  end
  assign data_o = mem_q[rp_q];
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges ALU (priority) and buffered LSU writebacks onto one regfile write port
import wb_pkg::*;
module regfile_wb_ctrl #(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = AW_DEF,
  parameter int DEPTH = 2
) (
  input logic i_clk,
  input logic i_rst,
  regfile_wb_ctrl_if.slave bus
);
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [XLEN-1:0] data;
  } req_t;
  req_t push_data, head;
  logic full, empty, alu_req, push, pop;
  logic wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  assign push_data = '{rd: bus.i_lsu_rd, data: bus.i_lsu_data};
  // x0 requests are dropped: ALU to x0 frees the port, LSU to x0 is accepted but not queued
  assign alu_req = bus.i_alu_valid && bus.i_alu_rd != '0;
  assign push = bus.i_lsu_valid && !full && bus.i_lsu_rd != '0;
  assign pop = !alu_req && !empty;
  wb_fifo #(.T(req_t), .DEPTH(DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push_i(push),
    .data_i(push_data),
    .pop_i(pop),
    .data_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(bus.o_fifo_count)
  );
  always_comb begin
    wr_en_d = alu_req || pop;
    wr_addr_d = alu_req ? bus.i_alu_rd : pop ? head.rd : wr_addr_q;
    wr_data_d = alu_req ? bus.i_alu_data : pop ? head.data : wr_data_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign bus.o_lsu_ready = !full;
  assign bus.o_wr_en = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: scoreboard bench with a queue-based reference of the LSU buffer
module tb_regfile_wb_ctrl;
  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  typedef struct {logic en; logic [AW-1:0] a; logic [XLEN-1:0] d;} wr_t;
  typedef struct {logic [AW-1:0] a; logic [XLEN-1:0] d;} ent_t;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  regfile_wb_ctrl_if #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) bus ();
  regfile_wb_ctrl #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  wr_t sb[$];
  ent_t mq[$];
  logic [AW-1:0] last_a = '0;
  logic [XLEN-1:0] last_d = '0;
  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // one clock: drive at negedge, predict, compare #1 after the rising edge
  task automatic cyc(input logic av, input logic [AW-1:0] ar, input logic [XLEN-1:0] ad,
                     input logic lv, input logic [AW-1:0] lr, input logic [XLEN-1:0] ldat,
                     output logic acc);
    wr_t w;
    ent_t e;
    bus.i_alu_valid = av;
    bus.i_alu_rd = ar;
    bus.i_alu_data = ad;
    bus.i_lsu_valid = lv;
    bus.i_lsu_rd = lr;
    bus.i_lsu_data = ldat;
    #1;
    check("lsu_ready", 64'(bus.o_lsu_ready), 64'(mq.size() < DEPTH));
    acc = lv && mq.size() < DEPTH;
    if (av && ar != 0) w = '{1'b1, ar, ad};
    else if (mq.size() != 0) begin
      e = mq.pop_front();
      w = '{1'b1, e.a, e.d};
    end else w = '{1'b0, last_a, last_d};
    last_a = w.a;
    last_d = w.d;
    sb.push_back(w);
    if (acc && lr != 0) mq.push_back('{lr, ldat});
    @(posedge clk);
    #1;
    w = sb.pop_front();
    check("wr_en", 64'(bus.o_wr_en), 64'(w.en));
    check("wr_addr", 64'(bus.o_wr_addr), 64'(w.a));
    check("wr_data", 64'(bus.o_wr_data), 64'(w.d));
    check("fifo_count", 64'(bus.o_fifo_count), 64'(mq.size()));
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, acc);
  endtask
  initial begin
    logic acc;
    int k;
    bus.i_alu_valid = 0;
    bus.i_alu_rd = 0;
    bus.i_alu_data = 0;
    bus.i_lsu_valid = 0;
    bus.i_lsu_rd = 0;
    bus.i_lsu_data = 0;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    check("rst_wr_en", 64'(bus.o_wr_en), 0);
    check("rst_wr_addr", 64'(bus.o_wr_addr), 0);
    check("rst_wr_data", 64'(bus.o_wr_data), 0);
    check("rst_count", 64'(bus.o_fifo_count), 0);
    check("rst_ready", 64'(bus.o_lsu_ready), 1);
    rst = 0;
    cyc(1, 3, 42, 0, 0, 0, acc);
    check("alu1_data", 64'(bus.o_wr_data), 42);
    cyc(1, 4, 512, 0, 0, 0, acc);
    idle(1);
    check("alu_hold_addr", 64'(bus.o_wr_addr), 4);
    cyc(0, 0, 0, 1, 7, 32'hDEADBEEF, acc);
    check("lsu_accept", 64'(acc), 1);
    check("lsu_count1", 64'(bus.o_fifo_count), 1);
    idle(1);
    check("lsu_data", 64'(bus.o_wr_data), 64'hDEADBEEF);
    idle(1);
    cyc(1, 5, 1, 1, 6, 2, acc);
    idle(2);
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1, AW'(i), XLEN'(i * 100), k < 3, AW'(10 + k), XLEN'(1000 + k), acc);
      if (acc) k++;
    end
    check("held_12", 64'(k), 2);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, k < 3, AW'(10 + k), XLEN'(1000 + k), acc);
      if (acc) k++;
    end
    check("all_lsu_accepted", 64'(k), 3);
    cyc(1, 1, 7, 1, 8, 88, acc);
    cyc(1, 0, 99, 0, 0, 0, acc);
    check("x0_drain_addr", 64'(bus.o_wr_addr), 8);
    cyc(0, 0, 0, 1, 0, 55, acc);
    check("lsu_x0_acc", 64'(acc), 1);
    idle(2);
    cyc(1, 2, 22, 1, 20, 200, acc);
    cyc(1, 3, 33, 1, 21, 210, acc);
    check("pre_rst_count", 64'(bus.o_fifo_count), 2);
    rst = 1;
    #1;
    check("arst_wr_en", 64'(bus.o_wr_en), 0);
    check("arst_wr_addr", 64'(bus.o_wr_addr), 0);
    check("arst_wr_data", 64'(bus.o_wr_data), 0);
    check("arst_count", 64'(bus.o_fifo_count), 0);
    mq.delete();
    sb.delete();
    last_a = '0;
    last_d = '0;
    @(negedge clk);
    rst = 0;
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-side controller for the 2-read/1-write register file (regfile_2r1w).
- Merges two writeback sources into the single regfile write port:
  - ALU: single-cycle result, cannot be back-pressured, has priority.
  - LSU: multi-cycle load result, valid/ready handshake.
- LSU results wait in a small FIFO whenever the write port is taken by the ALU.
- Drives the regfile i_wr_en / i_wr_addr / i_wr_data inputs from registered outputs.

Parameters:
- XLEN, 32, data width of the register file.
- AW, 5, register address width.
- DEPTH, 2, number of LSU FIFO entries; must be at least 1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_alu_valid  in  1  ALU writeback present this cycle.
- i_alu_rd  in  AW  ALU destination register.
- i_alu_data  in  XLEN  ALU result.
- i_lsu_valid  in  1  LSU writeback offered.
- o_lsu_ready  out  1  FIFO can accept an LSU writeback.
- i_lsu_rd  in  AW  LSU destination register.
- i_lsu_data  in  XLEN  load result.
- o_wr_en  out  1  regfile write enable.
- o_wr_addr  out  AW  regfile write address.
- o_wr_data  out  XLEN  regfile write data.
- o_fifo_count  out  clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, i_rst=1): o_wr_en=0, o_wr_addr=0, o_wr_data=0, FIFO empty, o_fifo_count=0, o_lsu_ready=1 (combinational from count).
- Handshake: o_lsu_ready = (count < DEPTH), taken from the registered count only, with no same-cycle pop look-ahead. An LSU transfer happens when i_lsu_valid && o_lsu_ready.
- Push: an accepted LSU writeback with rd != 0 is pushed at the FIFO tail. An accepted LSU writeback with rd == 0 is consumed and discarded, with no push.
- Write port arbitration, evaluated each cycle; results appear on o_wr_* at the next rising edge:
  1. If i_alu_valid && i_alu_rd != 0: o_wr_en=1 with the ALU rd/data. The FIFO does not pop.
  2. Else, if the FIFO is non-empty: pop the head; o_wr_en=1 with the head rd/data.
  3. Else: o_wr_en=0. o_wr_addr and o_wr_data hold their previous values.
- An ALU writeback to x0 counts as no request, so the FIFO head may drain in that cycle.
- Latency:
  - ALU: 1 cycle, input to o_wr_en.
  - LSU: minimum 2 cycles (push, then pop). There is no FIFO bypass.
- Simultaneous push and pop in one cycle: both happen and the count is unchanged.
  - Push while full cannot occur, because ready is low.
  - Pop while empty cannot occur.
- Pointers: the FIFO is a circular buffer. Pointers wrap modulo DEPTH and support non-power-of-2 DEPTH.
- Ordering:
  - LSU entries are written in arrival (FIFO) order.
  - Ordering between the ALU and LSU streams for the same rd is not guaranteed. The issue logic must prevent such WAW hazards.
- Starvation: continuous ALU writes may hold LSU entries indefinitely. The core stalls LSU issue while o_lsu_ready=0.
- Reset mid-operation: FIFO contents are lost and o_wr_en drops immediately (asynchronously).

Decomposition:
- Shared package wb_pkg holds:
  - the typedef wb_req_t {logic [AW-1:0] rd; logic [XLEN-1:0] data;}
  - the constants XLEN_DEF=32 and AW_DEF=5.
- One natural sub-module: wb_fifo, the parameterised circular FIFO of wb_req_t.
  - Ports: push/pop/full/empty/count.
  - Asynchronous active-high reset.
- regfile_wb_ctrl holds the arbitration and output registers.

Test Plan:
1. After reset, ALU-only stream: alu rd=3 data=42, then rd=4 data=512, then idle.
   -> o_wr_* = (1,3,42), then (1,4,512), then wr_en=0 with addr 4 held.
   -> A connected regfile_2r1w then reads 42 on rd_addr0=3 and 512 on rd_addr1=4.
2. LSU alone: lsu rd=7 data=0xDEADBEEF, one cycle, FIFO empty.
   -> Accepted (ready=1), count=1 the next cycle.
   -> o_wr_* = (1,7,0xDEADBEEF) two cycles after the input.
3. Collision: alu rd=5 data=1 and lsu rd=6 data=2 in the same cycle.
   -> Write (5,1) first, then (6,2) on the following edge.
   -> count goes 0 -> 1 -> 0.
4. Backpressure, DEPTH=2: ALU valid every cycle with rd=1..6; LSU offers rd=10,11,12 back-to-back.
   -> 10 and 11 accepted; ready=0 while count=2; 12 held until ALU idles.
   -> Once the ALU idles, 10, 11 and 12 drain in order.
5. x0 handling: alu rd=0 data=99 while the FIFO holds rd=8; separately, lsu rd=0.
   -> No write to x0. The rd=8 entry drains in the cycle the ALU targets x0. The LSU rd=0 request is consumed with no count change.
6. Reset mid-operation: assert i_rst while count=2 and o_wr_en=1.
   -> Outputs zero with no clock edge needed.
   -> After release: count=0 and no stale writes.
